byte_to_word_fcs_sn: RTL and testbench

Packs the receive byte stream from the 802.11 OFDM decoder (`dot11`) into 64-bit little-endian words for the DMA/FIFO path. After the last byte it appends one status word carrying the FCS check result and the receive packet sequence number. It sits directly after `dot11` in the receive datapath. It is cleared at every new packet header.

---
 rtl/rx_pkt_pkg.sv | 9 +
 rtl/byte_to_word_fcs_sn.sv | 116 +++++++++++
 tb/tb_byte_to_word_fcs_sn.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_pkt_pkg.sv
// Shared receive-packet constants: word geometry and the status-word layout
// that the DMA driver decodes.
package rx_pkt_pkg;
   localparam int WORD_W         = 64;
   localparam int BYTES_PER_WORD = 8;
   localparam int LANE_W         = $clog2(BYTES_PER_WORD);
   localparam int FCS_OK_BIT     = 0;
   localparam int SN_LSB         = 1;
endpackage

// File: rtl/byte_to_word_fcs_sn.sv
// Packs the dot11 receive byte stream into 64-bit little-endian words and
// appends one status word (FCS result + sequence number) per packet.
module byte_to_word_fcs_sn
   import rx_pkt_pkg::*;
#(
   parameter int SN_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          byte_in,
   input  logic                byte_in_strobe,
   input  logic [15:0]         byte_count,
   input  logic [15:0]         num_byte,
   input  logic                fcs_in_strobe,
   input  logic                fcs_ok,
   input  logic [SN_WIDTH-1:0] rx_pkt_sn_plus_one,
   output logic [WORD_W-1:0]   word_out,
   output logic                word_out_strobe
);

   logic [WORD_W-1:0]   acc_reg, acc_next;
   logic [WORD_W-1:0]   merged;
   logic [WORD_W-1:0]   word_next;
   logic                strobe_next;
   logic                pend_reg, pend_next;
   logic                done_reg, done_next;
   logic                fcs_ok_reg, fcs_ok_next;
   logic [SN_WIDTH-1:0] sn_reg, sn_next;

   logic [LANE_W-1:0] lane;
   logic              accept;
   logic              last_byte;
   logic              emit_data;
   logic              fcs_take;

   assign lane      = byte_count[LANE_W-1:0];
   assign accept    = byte_in_strobe && (byte_count < num_byte);
   assign last_byte = (byte_count == num_byte - 16'd1);
   assign emit_data = accept && ((lane == LANE_W'(BYTES_PER_WORD - 1)) || last_byte);
   assign fcs_take  = fcs_in_strobe && !done_reg;

   // Accumulator with the incoming byte dropped into its lane; emitted words use this directly.
   generate
      for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         assign merged[8*gi +: 8] = (accept && (lane == LANE_W'(gi))) ? byte_in
                                                                       : acc_reg[8*gi +: 8];
      end
   endgenerate

   function automatic logic [WORD_W-1:0] status_word(input logic ok,
                                                     input logic [SN_WIDTH-1:0] sn);
      logic [WORD_W-1:0] sw;
      sw                        = '0;
      sw[FCS_OK_BIT]            = ok;
      sw[SN_LSB +: SN_WIDTH]    = sn;
      return sw;
   endfunction

   always_comb begin
      acc_next    = acc_reg;
      pend_next   = pend_reg;
      done_next   = done_reg;
      fcs_ok_next = fcs_ok_reg;
      sn_next     = sn_reg;
      word_next   = word_out;
      strobe_next = 1'b0;

      if (accept) begin
         acc_next = merged;
      end
      if (emit_data) begin
         acc_next    = '0;
         word_next   = merged;
         strobe_next = 1'b1;
      end

      // A status collision with a data word is deferred by one cycle.
      if (pend_reg) begin
         pend_next   = 1'b0;
         word_next   = status_word(fcs_ok_reg, sn_reg);
         strobe_next = 1'b1;
      end else if (fcs_take) begin
         done_next = 1'b1;
         acc_next  = '0;
         if (emit_data) begin
            pend_next   = 1'b1;
            fcs_ok_next = fcs_ok;
            sn_next     = rx_pkt_sn_plus_one;
         end else begin
            word_next   = status_word(fcs_ok, rx_pkt_sn_plus_one);
            strobe_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg         <= '0;
         pend_reg        <= 1'b0;
         done_reg        <= 1'b0;
         fcs_ok_reg      <= 1'b0;
         sn_reg          <= '0;
         word_out        <= '0;
         word_out_strobe <= 1'b0;
      end else begin
         acc_reg         <= acc_next;
         pend_reg        <= pend_next;
         done_reg        <= done_next;
         fcs_ok_reg      <= fcs_ok_next;
         sn_reg          <= sn_next;
         word_out        <= word_next;
         word_out_strobe <= strobe_next;
      end
   end

endmodule

// File: tb/tb_byte_to_word_fcs_sn.sv
// Randomized bench for byte_to_word_fcs_sn: a byte-indexed packet model
// predicts every emitted word and the cycle it must appear on.
module tb_byte_to_word_fcs_sn;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  byte_in = '0;
   logic        byte_in_strobe = 1'b0;
   logic [15:0] byte_count = '0;
   logic [15:0] num_byte = '0;
   logic        fcs_in_strobe = 1'b0;
   logic        fcs_ok = 1'b0;
   logic [3:0]  rx_pkt_sn_plus_one = '0;
   logic [63:0] word_out;
   logic        word_out_strobe;

   byte_to_word_fcs_sn #(.SN_WIDTH(4)) dut (
      .clk                (clk),
      .rst                (rst),
      .byte_in            (byte_in),
      .byte_in_strobe     (byte_in_strobe),
      .byte_count         (byte_count),
      .num_byte           (num_byte),
      .fcs_in_strobe      (fcs_in_strobe),
      .fcs_ok             (fcs_ok),
      .rx_pkt_sn_plus_one (rx_pkt_sn_plus_one),
      .word_out           (word_out),
      .word_out_strobe    (word_out_strobe)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] got_w[$];
   int          got_c[$];
   logic [63:0] exp_w[$];
   int          exp_c[$];
   logic [7:0]  mem[int];
   bit          m_done = 1'b0;
   int          checks = 0;
   int          errors = 0;

   always @(negedge clk) begin
      if (word_out_strobe === 1'b1) begin
         got_w.push_back(word_out);
         got_c.push_back(cyc);
         $display("word %h at cycle %0d", word_out, cyc);
      end
   end

   // One input cycle; the model records which bytes the packet holds and
   // what words must come out, and when.
   task automatic drive(input bit bs, input logic [7:0] b, input int bc, input int nb,
                        input bit fs, input bit ok, input logic [3:0] sn);
      bit          coll;
      logic [63:0] w;
      int          g;
      @(negedge clk);
      byte_in_strobe     = bs;
      byte_in            = b;
      byte_count         = 16'(bc);
      num_byte           = 16'(nb);
      fcs_in_strobe      = fs;
      fcs_ok             = ok;
      rx_pkt_sn_plus_one = sn;
      coll = 1'b0;
      if (bs && bc < nb) begin
         mem[bc] = b;
         if ((bc % 8 == 7) || (bc == nb - 1)) begin
            g = bc / 8;
            w = '0;
            for (int l = 0; l < 8; l++) begin
               if (mem.exists(g * 8 + l)) begin
                  w[8*l +: 8] = mem[g * 8 + l];
                  mem.delete(g * 8 + l);
               end
            end
            exp_w.push_back(w);
            exp_c.push_back(cyc + 1);
            coll = 1'b1;
         end
      end
      if (fs && !m_done) begin
         m_done = 1'b1;
         mem.delete();
         exp_w.push_back(64'(ok) | (64'(sn) << 1));
         exp_c.push_back(cyc + (coll ? 2 : 1));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 0, 0, 0, 4'h0);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      byte_in_strobe = 1'b0;
      fcs_in_strobe  = 1'b0;
      rst            = 1'b1;
      mem.delete();
      m_done = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic flush_queues();
      got_w.delete(); got_c.delete(); exp_w.delete(); exp_c.delete();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (word_out !== 64'h0 || word_out_strobe !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got %h/%b want 0/0", word_out, word_out_strobe);
      end
      rst = 1'b0;
      drive(1, 8'h5A, 0, 1, 0, 0, 4'h0);
      idle(3);
      checks++;
      if (got_w.size() != 1 || got_w[0] !== 64'h5A) begin
         errors++;
         $display("FAIL reset_one_byte got %0d words want 1 word 5a", got_w.size());
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (word_out !== 64'h0 || word_out_strobe !== 1'b0) begin
         errors++;
         $display("FAIL reset_clears got %h/%b want 0/0", word_out, word_out_strobe);
      end
      rst = 1'b0;
      mem.delete();
      m_done = 1'b0;
      flush_queues();
   endtask

   task automatic test_seq16();
      pulse_rst();
      for (int i = 0; i < 16; i++) drive(1, 8'(i), i, 16, 0, 0, 4'h0);
      idle(4);
      checks++;
      if (got_w.size() != exp_w.size()) begin
         errors++;
         $display("FAIL seq16_count got %0d want %0d", got_w.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         checks++;
         if (got_w[i] !== exp_w[i] || got_c[i] != exp_c[i]) begin
            errors++;
            $display("FAIL seq16_word%0d got %h@%0d want %h@%0d", i, got_w[i], got_c[i], exp_w[i], exp_c[i]);
         end
      end
      checks++;
      if (word_out !== 64'h0F0E0D0C0B0A0908) begin
         errors++;
         $display("FAIL seq16_hold got %h want 0f0e0d0c0b0a0908", word_out);
      end
      flush_queues();
   endtask

   task automatic test_long_packet();
      pulse_rst();
      for (int i = 0; i < 100; i++) drive(1, 8'($urandom), i, 100, 0, 0, 4'h0);
      idle(2);
      drive(0, 8'h00, 100, 100, 1, 1, 4'd5);
      idle(4);
      checks++;
      if (got_w.size() != exp_w.size()) begin
         errors++;
         $display("FAIL long_count got %0d want %0d", got_w.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         checks++;
         if (got_w[i] !== exp_w[i] || got_c[i] != exp_c[i]) begin
            errors++;
            $display("FAIL long_word%0d got %h@%0d want %h@%0d", i, got_w[i], got_c[i], exp_w[i], exp_c[i]);
         end
      end
      flush_queues();
   endtask

   task automatic test_collision();
      pulse_rst();
      for (int i = 0; i < 16; i++) drive(1, 8'($urandom), i, 16, i == 15, 0, 4'h0);
      idle(4);
      checks++;
      if (got_w.size() != exp_w.size()) begin
         errors++;
         $display("FAIL collision_count got %0d want %0d", got_w.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         checks++;
         if (got_w[i] !== exp_w[i] || got_c[i] != exp_c[i]) begin
            errors++;
            $display("FAIL collision_word%0d got %h@%0d want %h@%0d", i, got_w[i], got_c[i], exp_w[i], exp_c[i]);
         end
      end
      flush_queues();
   endtask

   task automatic test_ignored();
      pulse_rst();
      for (int i = 0; i < 4; i++) drive(1, 8'($urandom), i, 4, 0, 0, 4'h0);
      drive(0, 8'h00, 4, 4, 1, 1, 4'd9);
      drive(1, 8'hEE, 4, 4, 0, 0, 4'h0);
      drive(1, 8'hEF, 7, 4, 0, 0, 4'h0);
      drive(1, 8'hF0, 9, 4, 0, 0, 4'h0);
      drive(0, 8'h00, 9, 4, 1, 0, 4'd3);
      idle(4);
      checks++;
      if (got_w.size() != exp_w.size()) begin
         errors++;
         $display("FAIL ignored_count got %0d want %0d", got_w.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         checks++;
         if (got_w[i] !== exp_w[i] || got_c[i] != exp_c[i]) begin
            errors++;
            $display("FAIL ignored_word%0d got %h@%0d want %h@%0d", i, got_w[i], got_c[i], exp_w[i], exp_c[i]);
         end
      end
      flush_queues();
   endtask

   task automatic test_rst_abort();
      pulse_rst();
      for (int i = 0; i < 4; i++) drive(1, 8'($urandom | 1), i, 8, 0, 0, 4'h0);
      pulse_rst();
      for (int i = 0; i < 8; i++) drive(1, 8'(8'hA0 + i), i, 8, 0, 0, 4'h0);
      idle(4);
      checks++;
      if (got_w.size() != exp_w.size()) begin
         errors++;
         $display("FAIL abort_count got %0d want %0d", got_w.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         checks++;
         if (got_w[i] !== exp_w[i] || got_c[i] != exp_c[i]) begin
            errors++;
            $display("FAIL abort_word%0d got %h@%0d want %h@%0d", i, got_w[i], got_c[i], exp_w[i], exp_c[i]);
         end
      end
      flush_queues();
   endtask

   task automatic test_zero_len();
      pulse_rst();
      idle(1);
      drive(0, 8'h00, 0, 0, 1, 1, 4'd15);
      idle(4);
      checks++;
      if (got_w.size() != 1 || got_w[0] !== 64'h1F) begin
         errors++;
         $display("FAIL zero_len got %0d words (first %h) want 1 word 1f",
                  got_w.size(), (got_w.size() > 0) ? got_w[0] : 64'h0);
      end
      flush_queues();
   endtask

   task automatic test_random();
      int  nb;
      bit  coll;
      bit  ok;
      logic [3:0] sn;
      for (int p = 0; p < 8; p++) begin
         pulse_rst();
         nb   = $urandom_range(0, 40);
         coll = ($urandom_range(0, 1) == 1) && (nb > 0);
         ok   = 1'($urandom);
         sn   = 4'($urandom);
         for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            drive(1, 8'($urandom), i, nb, coll && (i == nb - 1), ok, sn);
         end
         if (!coll) begin
            idle($urandom_range(0, 2));
            drive(0, 8'h00, nb, nb, 1, ok, sn);
         end
         idle(4);
         checks++;
         if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL random%0d_count got %0d want %0d", p, got_w.size(), exp_w.size());
         end
         for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i] || got_c[i] != exp_c[i]) begin
               errors++;
               $display("FAIL random%0d_word%0d got %h@%0d want %h@%0d",
                        p, i, got_w[i], got_c[i], exp_w[i], exp_c[i]);
            end
         end
         flush_queues();
      end
   endtask

   initial begin
      test_reset();
      test_seq16();
      test_long_packet();
      test_collision();
      test_ignored();
      test_rst_abort();
      test_zero_len();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
